// File: rtl/fp_lsu_pkg.sv
// fp_lsu shared definitions: FSM encoding and the word byte-enable.
// Imported by fp_lsu.
package fp_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/fp_lsu.sv
// FLW/FSW memory-side LSU: one word transaction in flight, stalls the core.
// FP_LSU_TIMEOUT_EN adds a REQ/WAIT watchdog of TIMEOUT_CYCLES cycles.
module fp_lsu
  import fp_lsu_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_store,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_rd,
  output logic          stall,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          fp_we,
  output logic [31:0]   fp_wd,
  output logic [4:0]    fp_rd,
  output logic          lsu_err
);

  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   fp_wd_q, fp_wd_d;
  logic [4:0]    rd_q, rd_d;
  logic          err_q, err_d;
  logic          aligned;
  logic          busy;
  logic          accept;
  logic          to_hit;

  assign aligned = (req_addr[1:0] == 2'b00);
  assign busy    = (state_q == REQ) || (state_q == WAIT);
  assign accept  = (state_q == IDLE) && req_valid && aligned;

`ifdef FP_LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = '0;
    else if (busy)
      cnt_d = cnt_q + 1'b1;
  end

  // Fires on the last allowed busy cycle, so REQ+WAIT lasts TIMEOUT_CYCLES
  assign to_hit = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    fp_wd_d = fp_wd_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && aligned) begin
          store_d = req_store;
          addr_d  = {req_addr[AW-1:2], 2'b00};
          wdata_d = req_wdata;
          rd_d    = req_rd;
          state_d = REQ;
        end else if (req_valid) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = WAIT;
        end else if (to_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = DONE;
          if (!store_q)
            fp_wd_d = mem_rdata;
        end else if (to_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      fp_wd_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      fp_wd_q <= fp_wd_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = busy || accept;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = (state_q == REQ) && store_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = BE_WORD;
  assign fp_we     = (state_q == DONE) && !store_q;
  assign fp_wd     = fp_wd_q;
  assign fp_rd     = rd_q;
  assign lsu_err   = err_q;

endmodule

// File: tb/tb_fp_lsu.sv
// Directed bench for fp_lsu with a simple grant/response memory model.
// Timeout scenario runs only when FP_LSU_TIMEOUT_EN is defined.
module tb_fp_lsu;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_store = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [4:0]    req_rd = '0;
  logic          stall;
  logic          mem_req;
  logic          mem_gnt = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          fp_we;
  logic [31:0]   fp_wd;
  logic [4:0]    fp_rd;
  logic          lsu_err;

  fp_lsu #(.AW(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fp_we(fp_we), .fp_wd(fp_wd), .fp_rd(fp_rd),
    .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  // monitor state
  int cyc = 0;
  int n_stall, n_req, n_memwe, n_err, hold_bad;
  int req_rise[$];
  int we_cyc[$];
  logic [31:0] we_data[$];
  logic [4:0]  we_rd[$];
  logic        prev_req = 1'b0;
  logic [31:0] seen_addr, seen_wdata;

  always @(negedge clk) begin
    cyc++;
    if (stall) n_stall++;
    if (mem_req) begin
      n_req++;
      if (mem_we) n_memwe++;
      if (!prev_req) begin
        req_rise.push_back(cyc);
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end else if (mem_addr !== seen_addr || mem_wdata !== seen_wdata) begin
        hold_bad++;
      end
    end
    prev_req = mem_req;
    if (fp_we) begin
      we_cyc.push_back(cyc);
      we_data.push_back(fp_wd);
      we_rd.push_back(fp_rd);
    end
    if (lsu_err) n_err++;
  end

  // memory responder: grant after gnt_dly REQ cycles, respond next cycle
  int          gnt_dly = 0;
  int          wcnt = 0;
  logic        mem_en = 1'b1;
  logic        hold_rsp = 1'b0;
  logic        gnt_prev = 1'b0;
  logic [31:0] rdq[$];

  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (gnt_prev && !hold_rsp) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (rdq.size() > 0) ? rdq.pop_front() : 32'hDEAD_BEEF;
      end
      gnt_prev = 1'b0;
      if (mem_req) begin
        if (wcnt >= gnt_dly) begin
          mem_gnt  = 1'b1;
          gnt_prev = 1'b1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic clr();
    n_stall  = 0;
    n_req    = 0;
    n_memwe  = 0;
    n_err    = 0;
    hold_bad = 0;
    req_rise.delete();
    we_cyc.delete();
    we_data.delete();
    we_rd.delete();
  endtask

  task automatic issue(input logic st, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = st;
    req_addr  = a;
    req_wdata = wd;
    req_rd    = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec++;
    if ({mem_req, mem_we, fp_we, lsu_err, stall} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {mem_req, mem_we, fp_we, lsu_err, stall});
    end
    vec++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || fp_wd !== 32'h0 ||
        fp_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_data addr=%h wd=%h fpwd=%h rd=%0d exp=0",
               mem_addr, mem_wdata, fp_wd, fp_rd);
    end
    vec++;
    if (mem_be !== 4'hF || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_be_rdy be=%h rdy=%b exp=f,1", mem_be, req_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    clr();
    gnt_dly = 0;
    rdq.push_back(32'h3F80_0000);
    issue(1'b0, 32'h10, 32'h0, 5'd5);
    repeat (6) @(posedge clk);
    #1;
    vec++;
    if (n_stall !== 3) begin
      bad++;
      $display("FAIL load_stall got=%0d exp=3", n_stall);
    end
    vec++;
    if (we_cyc.size() !== 1) begin
      bad++;
      $display("FAIL load_fpwe_cnt got=%0d exp=1", we_cyc.size());
    end else begin
      vec++;
      if (we_data[0] !== 32'h3F80_0000 || we_rd[0] !== 5'd5) begin
        bad++;
        $display("FAIL load_data got=%h/%0d exp=3f800000/5",
                 we_data[0], we_rd[0]);
      end
    end
    vec++;
    if (n_req !== 1 || n_memwe !== 0 || n_err !== 0) begin
      bad++;
      $display("FAIL load_req req=%0d we=%0d err=%0d exp=1,0,0",
               n_req, n_memwe, n_err);
    end
  endtask

  task automatic test_store();
    clr();
    gnt_dly = 4;
    issue(1'b1, 32'h20, 32'h4049_0FDB, 5'd7);
    repeat (10) @(posedge clk);
    #1;
    gnt_dly = 0;
    vec++;
    if (n_req !== 5 || n_memwe !== 5) begin
      bad++;
      $display("FAIL store_req req=%0d we=%0d exp=5,5", n_req, n_memwe);
    end
    vec++;
    if (seen_addr !== 32'h20 || seen_wdata !== 32'h4049_0FDB ||
        hold_bad !== 0) begin
      bad++;
      $display("FAIL store_bus addr=%h wd=%h unstable=%0d exp=20/40490fdb/0",
               seen_addr, seen_wdata, hold_bad);
    end
    vec++;
    if (we_cyc.size() !== 0 || n_stall !== 7) begin
      bad++;
      $display("FAIL store_wb fpwe=%0d stall=%0d exp=0,7",
               we_cyc.size(), n_stall);
    end
  endtask

  task automatic test_misaligned();
    clr();
    issue(1'b0, 32'h13, 32'h0, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (n_req !== 0 || n_err !== 1) begin
      bad++;
      $display("FAIL misal_err req=%0d err=%0d exp=0,1", n_req, n_err);
    end
    vec++;
    if (we_cyc.size() !== 0 || n_stall !== 0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL misal_state fpwe=%0d stall=%0d rdy=%b exp=0,0,1",
               we_cyc.size(), n_stall, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    clr();
    gnt_dly = 0;
    rdq.push_back(32'h1111_1111);
    rdq.push_back(32'h2222_2222);
    issue(1'b0, 32'h40, 32'h0, 5'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (fp_we) seen = 1'b1;
    end
    vec++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_first_done got=timeout exp=fp_we");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h44;
    req_rd    = 5'd2;
    @(negedge clk);
    vec++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept rdy=%b stall=%b exp=1,1", req_ready, stall);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    vec++;
    if (we_cyc.size() !== 2 || req_rise.size() !== 2) begin
      bad++;
      $display("FAIL b2b_cnt fpwe=%0d req=%0d exp=2,2",
               we_cyc.size(), req_rise.size());
    end else begin
      vec++;
      if (we_data[0] !== 32'h1111_1111 || we_rd[0] !== 5'd1 ||
          we_data[1] !== 32'h2222_2222 || we_rd[1] !== 5'd2) begin
        bad++;
        $display("FAIL b2b_data got=%h/%0d %h/%0d exp=11111111/1 22222222/2",
                 we_data[0], we_rd[0], we_data[1], we_rd[1]);
      end
      vec++;
      if (req_rise[1] !== we_cyc[0] + 2 || we_cyc[1] !== we_cyc[0] + 4) begin
        bad++;
        $display("FAIL b2b_timing req2=%0d we2=%0d exp=%0d,%0d",
                 req_rise[1], we_cyc[1], we_cyc[0] + 2, we_cyc[0] + 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    clr();
    gnt_dly  = 0;
    hold_rsp = 1'b1;
    issue(1'b0, 32'h30, 32'h0, 5'd9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vec++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1 ||
        mem_addr !== 32'h0 || fp_rd !== 5'd0) begin
      bad++;
      $display("FAIL rstmid_async req=%b stall=%b rdy=%b addr=%h rd=%0d exp=0,0,1,0,0",
               mem_req, stall, req_ready, mem_addr, fp_rd);
    end
    mem_en   = 1'b0;
    hold_rsp = 1'b0;
    gnt_prev = 1'b0;
    mem_gnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_en = 1'b1;
    vec++;
    if (we_cyc.size() !== 0 || fp_wd !== 32'h0 || n_err !== 0) begin
      bad++;
      $display("FAIL rstmid_stale fpwe=%0d fpwd=%h err=%0d exp=0,0,0",
               we_cyc.size(), fp_wd, n_err);
    end
    vec++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 ||
        mem_be !== 4'hF) begin
      bad++;
      $display("FAIL rstmid_idle rdy=%b stall=%b req=%b be=%h exp=1,0,0,f",
               req_ready, stall, mem_req, mem_be);
    end
  endtask

`ifdef FP_LSU_TIMEOUT_EN
  task automatic test_timeout();
    clr();
    gnt_dly = 1000;
    issue(1'b1, 32'h50, 32'h1234_5678, 5'd0);
    repeat (12) @(posedge clk);
    #1;
    gnt_dly = 0;
    vec++;
    if (n_req !== 8 || n_err !== 1) begin
      bad++;
      $display("FAIL timeout_err req=%0d err=%0d exp=8,1", n_req, n_err);
    end
    vec++;
    if (we_cyc.size() !== 0 || n_stall !== 9 || req_ready !== 1'b1 ||
        mem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_rel fpwe=%0d stall=%0d rdy=%b req=%b exp=0,9,1,0",
               we_cyc.size(), n_stall, req_ready, mem_req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
`ifdef FP_LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
